// File: rtl/exe_stage_pipe.sv
// Registered ARM execute stage: Val2 generation, ALU, multi-cycle MUL/MLA and branch target,
// feeding an EXE/MEM output register with valid/ready flow control on both sides.
module exe_stage_pipe #(
  parameter int DATA_W     = 32,
  parameter int IMM_W      = 24,
  parameter int MUL_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        exec_cmd,
  input  logic              is_mul,
  input  logic              accumulate,
  input  logic              mem_read_enable,
  input  logic              mem_write_enable,
  input  logic              immidiate,
  input  logic [3:0]        Status,
  input  logic [11:0]       shift_operand,
  input  logic [IMM_W-1:0]  Signed_immidiate_24,
  input  logic [DATA_W-1:0] PC_in,
  input  logic [DATA_W-1:0] Val_Rn,
  input  logic [DATA_W-1:0] Val_Rm,
  input  logic [DATA_W-1:0] Val_Ra,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_out,
  output logic [3:0]        Status_out,
  output logic [DATA_W-1:0] jump_addr,
  output logic              dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready; valid never
  // depends on ready, and a held result keeps its data stable until it is taken.
  typedef enum logic {IDLE, MUL} state_t;

  localparam bit FAST_MUL = (MUL_CYCLES == 1);
  localparam int CNT_W    = $clog2(MUL_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] mul_a, mul_b, mul_c;
  logic [1:0]        mul_st;
  logic              accept, load_out, start_mul;

  assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign dbg_state = (state == MUL);

  // Operand 2
  logic [31:0]       imm32, imm_rot;
  logic [4:0]        rot, sh_amt;
  logic [DATA_W-1:0] val2, rm_asr;

  assign imm32   = {24'b0, shift_operand[7:0]};
  assign rot     = {shift_operand[11:8], 1'b0};
  assign imm_rot = (imm32 >> rot) | (imm32 << (6'd32 - {1'b0, rot}));
  assign sh_amt  = shift_operand[11:7];
  assign rm_asr  = $signed(Val_Rm) >>> sh_amt;

  always_comb begin
    val2 = Val_Rm;
    if (immidiate) begin
      val2 = DATA_W'(imm_rot);
    end else if (mem_read_enable || mem_write_enable) begin
      val2 = DATA_W'(shift_operand);
    end else begin
      case (shift_operand[6:5])
        2'b00:   val2 = Val_Rm << sh_amt;
        2'b01:   val2 = Val_Rm >> sh_amt;
        2'b10:   val2 = rm_asr;
        default: val2 = (Val_Rm >> sh_amt) | (Val_Rm << (7'(DATA_W) - {2'b0, sh_amt}));
      endcase
    end
  end

  // ALU: subtraction is Rn + ~Val2 + carry, so the carry-out is already NOT borrow
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] b_op, alu_res;
  logic              c_in, arith, logic_op;
  logic [3:0]        alu_flags;

  always_comb begin
    b_op      = val2;
    c_in      = 1'b0;
    arith     = 1'b0;
    logic_op  = 1'b0;
    alu_res   = '0;
    alu_flags = Status;
    case (exec_cmd)
      4'b0011: c_in = Status[1];
      4'b0100: begin b_op = ~val2; c_in = 1'b1; end
      4'b0101: begin b_op = ~val2; c_in = Status[1]; end
      default: ;
    endcase
    sum = {1'b0, Val_Rn} + {1'b0, b_op} + {{DATA_W{1'b0}}, c_in};
    case (exec_cmd)
      4'b0001: begin alu_res = val2;          logic_op = 1'b1; end
      4'b1001: begin alu_res = ~val2;         logic_op = 1'b1; end
      4'b0110: begin alu_res = Val_Rn & val2; logic_op = 1'b1; end
      4'b0111: begin alu_res = Val_Rn | val2; logic_op = 1'b1; end
      4'b1000: begin alu_res = Val_Rn ^ val2; logic_op = 1'b1; end
      4'b0010, 4'b0011, 4'b0100, 4'b0101: begin
        alu_res = sum[DATA_W-1:0];
        arith   = 1'b1;
      end
      default: ;
    endcase
    if (arith) begin
      alu_flags = {alu_res[DATA_W-1], alu_res == '0, sum[DATA_W],
                   (Val_Rn[DATA_W-1] == b_op[DATA_W-1]) && (alu_res[DATA_W-1] != Val_Rn[DATA_W-1])};
    end else if (logic_op) begin
      alu_flags = {alu_res[DATA_W-1], alu_res == '0, Status[1:0]};
    end
  end

  // One multiplier: live operands for the single-cycle case, latched ones while in MUL
  logic [DATA_W-1:0] mul_x, mul_y, mul_acc, mul_res, res_d;
  logic [1:0]        mul_cv;
  logic [3:0]        flags_d;
  logic              use_mul;

  assign mul_x   = (state == MUL) ? mul_a : Val_Rn;
  assign mul_y   = (state == MUL) ? mul_b : Val_Rm;
  assign mul_acc = (state == MUL) ? mul_c : (accumulate ? Val_Ra : '0);
  assign mul_cv  = (state == MUL) ? mul_st : Status[1:0];
  assign mul_res = mul_x * mul_y + mul_acc;
  assign use_mul = (state == MUL) || is_mul;
  assign res_d   = use_mul ? mul_res : alu_res;
  assign flags_d = use_mul ? {mul_res[DATA_W-1], mul_res == '0, mul_cv} : alu_flags;

  logic [DATA_W-1:0] imm_ext, target;
  assign imm_ext = DATA_W'($signed(Signed_immidiate_24));
  assign target  = PC_in + imm_ext;

  always_comb begin
    state_next = state;
    load_out   = 1'b0;
    start_mul  = 1'b0;
    case (state)
      IDLE: if (accept) begin
        if (is_mul && !FAST_MUL) begin
          state_next = MUL;
          start_mul  = 1'b1;
        end else begin
          load_out = 1'b1;
        end
      end
      MUL: if (cnt == '0) begin
        state_next = IDLE;
        load_out   = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      alu_out    <= '0;
      Status_out <= '0;
      jump_addr  <= '0;
      cnt        <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_c      <= '0;
      mul_st     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (load_out) begin
        out_valid  <= 1'b1;
        alu_out    <= res_d;
        Status_out <= flags_d;
      end
      if (accept) jump_addr <= {target[DATA_W-1:2], 2'b00};
      if (start_mul) begin
        mul_a  <= Val_Rn;
        mul_b  <= Val_Rm;
        mul_c  <= accumulate ? Val_Ra : '0;
        mul_st <= Status[1:0];
        cnt    <= CNT_LOAD;
      end else if (state == MUL && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_exe_stage_pipe.sv
// Bench for exe_stage_pipe: directed scenarios then random traffic, checked against an
// arithmetic reference model with a result queue standing for the output register.
module tb_exe_stage_pipe;
  localparam int DW = 32;
  localparam int IW = 24;
  localparam int MC = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, in_valid, in_ready, is_mul, accumulate;
  logic          mem_read_enable, mem_write_enable, immidiate, out_valid, out_ready, dbg_state;
  logic [3:0]    exec_cmd, Status, Status_out;
  logic [11:0]   shift_operand;
  logic [IW-1:0] Signed_immidiate_24;
  logic [DW-1:0] PC_in, Val_Rn, Val_Rm, Val_Ra, alu_out, jump_addr;

  exe_stage_pipe #(.DATA_W(DW), .IMM_W(IW), .MUL_CYCLES(MC)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .exec_cmd(exec_cmd), .is_mul(is_mul), .accumulate(accumulate),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .immidiate(immidiate), .Status(Status), .shift_operand(shift_operand),
    .Signed_immidiate_24(Signed_immidiate_24), .PC_in(PC_in), .Val_Rn(Val_Rn),
    .Val_Rm(Val_Rm), .Val_Ra(Val_Ra), .out_valid(out_valid), .out_ready(out_ready),
    .alu_out(alu_out), .Status_out(Status_out), .jump_addr(jump_addr), .dbg_state(dbg_state)
  );

  int chk_cnt = 0;
  int err_cnt = 0;

  // scoreboard: {alu_out, Status_out, jump_addr}
  logic [67:0] exp_q[$];
  int          m_busy = 0;
  logic [67:0] m_pend;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint sx32(input logic [31:0] x);
    longint r;
    r = $signed(x);
    return r;
  endfunction

  function automatic logic [31:0] ref_jump();
    longint unsigned t;
    longint o;
    o = $signed(Signed_immidiate_24);
    t = PC_in;
    t = (t + o) & 64'hFFFF_FFFC;
    return t[31:0];
  endfunction

  function automatic logic [67:0] ref_op();
    longint unsigned m32 = 64'hFFFF_FFFF;
    longint unsigned rn, rm, v2, r, cin, bor;
    longint s, sv, smax, smin;
    int sh;
    logic c, v, ar;
    smax = 2147483647;
    smin = -smax - 1;
    rn  = Val_Rn;
    rm  = Val_Rm;
    cin = Status[1];
    c   = Status[1];
    v   = Status[0];
    ar  = 1'b0;
    s   = 0;
    if (is_mul) begin
      r = rn * rm;
      if (accumulate) r = r + Val_Ra;
      r = r & m32;
      return {r[31:0], r[31], r[31:0] == 32'h0, Status[1:0], ref_jump()};
    end
    if (immidiate) begin
      sh = 2 * int'(shift_operand[11:8]);
      v2 = shift_operand[7:0];
      if (sh != 0) v2 = ((v2 >> sh) | (v2 << (32 - sh))) & m32;
    end else if (mem_read_enable || mem_write_enable) begin
      v2 = shift_operand;
    end else begin
      sh = int'(shift_operand[11:7]);
      case (shift_operand[6:5])
        2'd0: v2 = (rm << sh) & m32;
        2'd1: v2 = rm >> sh;
        2'd2: begin sv = sx32(Val_Rm); sv = sv >>> sh; v2 = sv; v2 = v2 & m32; end
        default: v2 = (sh == 0) ? rm : (((rm >> sh) | (rm << (32 - sh))) & m32);
      endcase
    end
    case (exec_cmd)
      4'h1: r = v2;
      4'h9: r = ~v2 & m32;
      4'h2, 4'h3: begin
        if (exec_cmd == 4'h2) cin = 0;
        r  = rn + v2 + cin;
        c  = r[32];
        s  = sx32(rn[31:0]) + sx32(v2[31:0]) + longint'(cin);
        ar = 1'b1;
      end
      4'h4, 4'h5: begin
        bor = (exec_cmd == 4'h5) ? longint'(!Status[1]) : 0;
        c   = (rn >= v2 + bor);
        r   = rn - v2 - bor;
        s   = sx32(rn[31:0]) - sx32(v2[31:0]) - longint'(bor);
        ar  = 1'b1;
      end
      4'h6: r = rn & v2;
      4'h7: r = rn | v2;
      4'h8: r = rn ^ v2;
      default: return {32'h0, Status, ref_jump()};
    endcase
    r = r & m32;
    if (ar) v = (s > smax) || (s < smin);
    return {r[31:0], r[31], r[31:0] == 32'h0, c, v, ref_jump()};
  endfunction

  // driver tasks
  task automatic set_idle();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    exec_cmd = 4'h0; is_mul = 1'b0; accumulate = 1'b0;
    mem_read_enable = 1'b0; mem_write_enable = 1'b0; immidiate = 1'b0;
    Status = 4'h0; shift_operand = 12'h0; Signed_immidiate_24 = '0;
    PC_in = '0; Val_Rn = '0; Val_Rm = '0; Val_Ra = '0;
  endtask

  task automatic drive_random();
    rst              = ($urandom_range(0, 299) == 0);
    flush            = ($urandom_range(0, 24) == 0);
    in_valid         = ($urandom_range(0, 9) < 7);
    out_ready        = ($urandom_range(0, 9) < 7);
    exec_cmd         = 4'($urandom_range(0, 15));
    is_mul           = ($urandom_range(0, 7) == 0);
    accumulate       = ($urandom_range(0, 1) == 1);
    mem_read_enable  = ($urandom_range(0, 9) == 0);
    mem_write_enable = ($urandom_range(0, 9) == 0);
    immidiate        = ($urandom_range(0, 2) == 0);
    Status           = 4'($urandom_range(0, 15));
    shift_operand    = 12'($urandom_range(0, 4095));
    Signed_immidiate_24 = 24'($urandom);
    PC_in  = $urandom;
    Val_Rn = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    Val_Rm = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    Val_Ra = $urandom;
    if ($urandom_range(0, 7) == 0) Val_Rm = Val_Rn;
  endtask

  // one clock: compare against the model, advance the model, move to the next falling edge
  task automatic step();
    logic        exp_ready;
    logic [67:0] e, r;
    #1;
    exp_ready = (m_busy == 0) && ((exp_q.size() == 0) || out_ready);
    check("in_ready", 64'(in_ready), 64'(exp_ready));
    check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    check("mul_state", 64'(dbg_state), 64'(m_busy != 0));
    if (exp_q.size() != 0 && out_ready) begin
      e = exp_q.pop_front();
      check("alu_out", 64'(alu_out), 64'(e[67:36]));
      check("status_out", 64'(Status_out), 64'(e[35:32]));
      check("jump_addr", 64'(jump_addr), 64'(e[31:0]));
    end
    if (rst || flush) begin
      exp_q.delete();
      m_busy = 0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) exp_q.push_back(m_pend);
    end else if (in_valid && exp_ready) begin
      r = ref_op();
      if (is_mul && MC > 1) begin
        m_busy = MC;
        m_pend = r;
      end else begin
        exp_q.push_back(r);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_alu", 64'(alu_out), 64'd0);
    check("rst_status", 64'(Status_out), 64'd0);
    check("rst_jump", 64'(jump_addr), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;

    // ADD 5 + imm 7
    in_valid = 1'b1; exec_cmd = 4'b0010; immidiate = 1'b1; shift_operand = 12'h007; Val_Rn = 32'd5;
    step();
    in_valid = 1'b0;
    check("add_valid", 64'(out_valid), 64'd1);
    check("add_alu", 64'(alu_out), 64'd12);
    check("add_status", 64'(Status_out), 64'h0);
    step();

    // SUB flags
    in_valid = 1'b1; exec_cmd = 4'b0100; shift_operand = 12'h003; Val_Rn = 32'd3;
    step();
    in_valid = 1'b0;
    check("sub_eq_alu", 64'(alu_out), 64'd0);
    check("sub_eq_status", 64'(Status_out), 64'b0110);
    step();
    in_valid = 1'b1; shift_operand = 12'h001; Val_Rn = 32'd0;
    step();
    in_valid = 1'b0;
    check("sub_neg_alu", 64'(alu_out), 64'hFFFF_FFFF);
    check("sub_neg_status", 64'(Status_out), 64'b1000);
    step();

    // MLA 6*7+2, operands changed after accept
    in_valid = 1'b1; immidiate = 1'b0; shift_operand = 12'h0; exec_cmd = 4'h0;
    is_mul = 1'b1; accumulate = 1'b1; Val_Rn = 32'd6; Val_Rm = 32'd7; Val_Ra = 32'd2;
    step();
    in_valid = 1'b0; Val_Rn = 32'd99; Val_Rm = 32'd99; Val_Ra = 32'd99;
    for (int i = 0; i < MC; i++) begin
      #1;
      check("mla_stall", 64'(in_ready), 64'd0);
      step();
    end
    check("mla_valid", 64'(out_valid), 64'd1);
    check("mla_alu", 64'(alu_out), 64'd44);
    is_mul = 1'b0; accumulate = 1'b0;
    step();

    // backpressure
    in_valid = 1'b1; exec_cmd = 4'b0010; immidiate = 1'b1; shift_operand = 12'h001;
    Val_Rn = 32'd100; out_ready = 1'b0;
    step();
    Val_Rn = 32'd200;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready", 64'(in_ready), 64'd0);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_alu", 64'(alu_out), 64'd101);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check("bp_new_valid", 64'(out_valid), 64'd1);
    check("bp_new_alu", 64'(alu_out), 64'd201);
    step();

    // flush two cycles after a MUL accept
    in_valid = 1'b1; is_mul = 1'b1; Val_Rn = 32'd3; Val_Rm = 32'd5;
    step();
    in_valid = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0; is_mul = 1'b0;
    #1;
    check("flush_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < MC + 1; i++) begin
      check("flush_no_valid", 64'(out_valid), 64'd0);
      step();
    end

    // branch target
    in_valid = 1'b1; exec_cmd = 4'b0001; PC_in = 32'h100; Signed_immidiate_24 = 24'hFFFFFE;
    step();
    in_valid = 1'b0;
    check("branch_jump", 64'(jump_addr), 64'hFC);
    step();

    // reset during MUL
    in_valid = 1'b1; is_mul = 1'b1; Val_Rn = 32'd9; Val_Rm = 32'd9; PC_in = 32'h2000;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; is_mul = 1'b0;
    check("rstmul_valid", 64'(out_valid), 64'd0);
    check("rstmul_alu", 64'(alu_out), 64'd0);
    check("rstmul_status", 64'(Status_out), 64'd0);
    check("rstmul_jump", 64'(jump_addr), 64'd0);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      drive_random();
      step();
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
